block_lock_fsm: RTL
===================

# block_lock_fsm

Sync-header lock controller for the 100GbE PCS receive path. It examines the per-block sync-header verdict produced by the block-sync aligner and decides when the aligner's current bit offset is correct. It drives the aligner's search index through slip pulses and asserts block lock using the Clause 82 style 64/1024/65 rules. It sits between the aligner datapath and the lane deskew stage; downstream stages qualify data with its `o_block_lock`.

## Interface
Parameters:
- `NB_CODED_BLOCK`, 66, coded block width; search index range is 0..NB_CODED_BLOCK-1.
- `N_UNLOCKED_WINDOW`, 64, consecutive valid headers required to acquire lock.
- `N_LOCKED_WINDOW`, 1024, monitoring window length while locked.
- `MAX_INVALID_SH`, 65, invalid headers within one locked window that force loss of lock.
- `SLIP_HOLDOFF`, 4, blocks ignored after a slip; used only with the macro.

Ports:
- `i_clock`  in  1  single clock.
- `i_reset`  in  1  asynchronous, active-low reset.
- `i_valid`  in  1  qualifies `i_sh_valid` for one block this cycle.
- `i_signal_ok`  in  1  PMA signal indication; low forces unlock.
- `i_sh_valid`  in  1  1 = current block header is 01 or 10; 0 = 00 or 11.
- `o_block_lock`  out  1  registered lock flag.
- `o_slip`  out  1  one-cycle pulse; the aligner advances its offset by one bit.
- `o_search_index`  out  $clog2(NB_CODED_BLOCK)  current offset applied by the aligner, mirrored here.

## Operation
- Internal counters:
  - `sh_cnt`: $clog2(N_LOCKED_WINDOW)+1 bits.
  - `invalid_cnt`: $clog2(MAX_INVALID_SH)+1 bits.
  - Both saturate-free; widths cover the maximum count plus one.
- States:
  - **INIT**: `o_block_lock`=0, counters cleared. Moves to TEST when `i_signal_ok`=1.
  - **TEST**: only cycles with `i_valid`=1 are evaluated.
    - Unlocked, `i_sh_valid`=1: `sh_cnt`++. When `sh_cnt` reaches N_UNLOCKED_WINDOW, set lock and clear counters.
    - Unlocked, `i_sh_valid`=0: go to SLIP.
    - Locked: `sh_cnt`++ on every valid block; `invalid_cnt`++ on each invalid header.
    - Locked, `invalid_cnt` reaches MAX_INVALID_SH: clear lock and go to SLIP.
    - Locked, `sh_cnt` reaches N_LOCKED_WINDOW with `invalid_cnt` < MAX_INVALID_SH: clear both counters, stay locked.
    - If the final block of a window is also the 65th invalid header, the invalid-count rule wins.
  - **SLIP**:
    - One cycle: `o_slip`=1, counters cleared, `o_block_lock`=0.
    - `o_search_index` increments, wrapping from NB_CODED_BLOCK-1 to 0.
    - Returns to TEST, or to HOLDOFF when the macro is defined.
  - **HOLDOFF** (macro only): discards SLIP_HOLDOFF valid blocks, then returns to TEST.
- `i_signal_ok`=0 in any state: next state is INIT, lock cleared, counters cleared, no slip. `o_search_index` keeps its value.
- `i_valid`=0: counters and state hold. Exception: the SLIP state always completes in one cycle.

## Timing
- Reset values: `o_block_lock`=0, `o_slip`=0, `o_search_index`=0, state INIT, counters 0.
- All outputs are registered.
- For a deciding block sampled at edge t:
  - `o_block_lock` changes after edge t.
  - `o_slip` is high during the cycle after edge t+1, for exactly one cycle.
  - `o_search_index` updates on the same edge that drops `o_slip`.
- Minimum spacing between slips:
  - Without the macro: 2 cycles (SLIP → TEST → first invalid → SLIP).
  - With the macro: 2+SLIP_HOLDOFF valid cycles.
- Reset asserted mid-lock or mid-slip clears everything asynchronously. The first evaluation happens in the second cycle after deassertion with `i_signal_ok`=1.

## Configuration
- `BLOCK_LOCK_SLIP_HOLDOFF_EN`
  - Defined: the HOLDOFF state exists. The next SLIP_HOLDOFF valid blocks after each slip are not counted, covering the aligner's barrel-shifter pipeline latency.
  - Undefined: SLIP returns directly to TEST and the SLIP_HOLDOFF parameter is unused.

## Test plan
- **Acquire lock**: reset, then `i_signal_ok`=1 with 64 valid blocks `i_sh_valid`=1 → `o_block_lock` rises exactly after the 64th; `o_slip` never pulses; index stays 0.
- **Early invalid**: 10 valid headers, then 1 invalid → single `o_slip` pulse; index 0→1; 64 further good headers needed for lock (not 54).
- **Locked, tolerated errors**: after lock, 1024 blocks containing 64 invalid → lock held; counters restart. Next window with 65 invalid → lock drops on the 65th, one slip, index +1.
- **Index wrap**: force 66 consecutive slips from index 0 → index reaches 65, then returns to 0; exactly 66 `o_slip` pulses.
- **Signal loss**: drop `i_signal_ok` while locked at index 37 → lock 0 next cycle, no slip, index stays 37. Restore → 64 good headers relock at 37.
- **Reset mid-operation and holdoff**: async reset during SLIP → all outputs 0 immediately. With the macro, 4 invalid blocks right after a slip cause no second slip.

Source files
------------

// File: rtl/block_lock_fsm.sv
// block_lock_fsm: sync-header lock controller for the 100GbE PCS receive path.
// Judges the aligner's per-block header verdicts, steers its bit offset with
// slip pulses and raises block lock using the 64 / 1024 / 65 rules.
// Ports: i_clock, i_reset (async, active low), i_valid, i_signal_ok,
//        i_sh_valid -> o_block_lock, o_slip, o_search_index (all registered).
// Option: define BLOCK_LOCK_SLIP_HOLDOFF_EN to ignore SLIP_HOLDOFF valid
//         blocks after each slip while the aligner's shifter pipeline refills.
module block_lock_fsm #(
   parameter int NB_CODED_BLOCK    = 66,
   parameter int N_UNLOCKED_WINDOW = 64,
   parameter int N_LOCKED_WINDOW   = 1024,
   parameter int MAX_INVALID_SH    = 65,
   parameter int SLIP_HOLDOFF      = 4
) (
   input  logic                              i_clock,
   input  logic                              i_reset,
   input  logic                              i_valid,
   input  logic                              i_signal_ok,
   input  logic                              i_sh_valid,
   output logic                              o_block_lock,
   output logic                              o_slip,
   output logic [$clog2(NB_CODED_BLOCK)-1:0] o_search_index
);

   localparam int IDX_W  = $clog2(NB_CODED_BLOCK);
   // sh_cnt also paces the holdoff, so it must cover that count too
   localparam int SH_MAX = (SLIP_HOLDOFF > N_LOCKED_WINDOW) ?
                           SLIP_HOLDOFF : N_LOCKED_WINDOW;
   localparam int SH_W   = $clog2(SH_MAX) + 1;
   localparam int INV_W  = $clog2(MAX_INVALID_SH) + 1;

   typedef enum logic [1:0] {
      INIT    = 2'd0,
      TEST    = 2'd1,
      SLIP    = 2'd2,
      HOLDOFF = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic [SH_W-1:0]  sh_cnt, sh_nxt, sh_inc;
   logic [INV_W-1:0] invalid_cnt, inv_nxt, inv_inc;
   logic             lock_nxt;
   logic             slip_nxt;

   // state register
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state          <= INIT;
         sh_cnt         <= '0;
         invalid_cnt    <= '0;
         o_block_lock   <= 1'b0;
         o_slip         <= 1'b0;
         o_search_index <= '0;
      end else begin
         state        <= state_nxt;
         sh_cnt       <= sh_nxt;
         invalid_cnt  <= inv_nxt;
         o_block_lock <= lock_nxt;
         o_slip       <= slip_nxt;
         // the aligner moves on the edge that ends the slip pulse
         if (o_slip) begin
            if (o_search_index == IDX_W'(NB_CODED_BLOCK - 1))
               o_search_index <= '0;
            else
               o_search_index <= o_search_index + IDX_W'(1);
         end
      end
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      sh_nxt    = sh_cnt;
      inv_nxt   = invalid_cnt;
      lock_nxt  = o_block_lock;
      sh_inc    = sh_cnt + SH_W'(1);
      inv_inc   = i_sh_valid ? invalid_cnt : invalid_cnt + INV_W'(1);

      if (!i_signal_ok) begin
         state_nxt = INIT;
         sh_nxt    = '0;
         inv_nxt   = '0;
         lock_nxt  = 1'b0;
      end else begin
         unique case (state)
            INIT: begin
               state_nxt = TEST;
               sh_nxt    = '0;
               inv_nxt   = '0;
               lock_nxt  = 1'b0;
            end
            TEST: begin
               if (i_valid) begin
                  if (!o_block_lock) begin
                     if (!i_sh_valid) begin
                        state_nxt = SLIP;
                        sh_nxt    = '0;
                        inv_nxt   = '0;
                     end else if (sh_inc == SH_W'(N_UNLOCKED_WINDOW)) begin
                        lock_nxt  = 1'b1;
                        sh_nxt    = '0;
                        inv_nxt   = '0;
                     end else begin
                        sh_nxt    = sh_inc;
                     end
                  end else begin
                     // invalid limit is tested first so it wins on the
                     // last block of a window
                     if (inv_inc == INV_W'(MAX_INVALID_SH)) begin
                        state_nxt = SLIP;
                        lock_nxt  = 1'b0;
                        sh_nxt    = '0;
                        inv_nxt   = '0;
                     end else if (sh_inc == SH_W'(N_LOCKED_WINDOW)) begin
                        sh_nxt    = '0;
                        inv_nxt   = '0;
                     end else begin
                        sh_nxt    = sh_inc;
                        inv_nxt   = inv_inc;
                     end
                  end
               end
            end
            SLIP: begin
               sh_nxt    = '0;
               inv_nxt   = '0;
               lock_nxt  = 1'b0;
`ifdef BLOCK_LOCK_SLIP_HOLDOFF_EN
               state_nxt = HOLDOFF;
`else
               state_nxt = TEST;
`endif
            end
`ifdef BLOCK_LOCK_SLIP_HOLDOFF_EN
            HOLDOFF: begin
               if (i_valid) begin
                  if (sh_inc == SH_W'(SLIP_HOLDOFF)) begin
                     state_nxt = TEST;
                     sh_nxt    = '0;
                  end else begin
                     sh_nxt    = sh_inc;
                  end
               end
            end
`endif
            default: begin
               state_nxt = INIT;
               sh_nxt    = '0;
               inv_nxt   = '0;
               lock_nxt  = 1'b0;
            end
         endcase
      end
   end

   // output logic: the slip pulse follows one cycle spent in SLIP
   always_comb begin
      slip_nxt = 1'b0;
      if (state == SLIP && i_signal_ok)
         slip_nxt = 1'b1;
   end

endmodule
